// File: rtl/pipemem_pkg.sv
// Shared encodings and widths for the instruction/data cache memory-port arbiter.
package pipemem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_e;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RUN_W  = 4;
    localparam int WDOG_W = 8;

    // Saturating increment used by the data-run starvation counter.
    function automatic logic [RUN_W-1:0] run_inc(input logic [RUN_W-1:0] v,
                                                 input logic [RUN_W-1:0] lim);
        return (v >= lim) ? lim : RUN_W'(v + 1'b1);
    endfunction

endpackage

// File: rtl/pipemem_wdog.sv
// Grant watchdog: counts grant cycles without memory completion and latches a sticky error.
module pipemem_wdog
    import pipemem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_err
);

    localparam logic [WDOG_W-1:0] C_LIMIT = WDOG_W'(TIMEOUT);

    logic [WDOG_W-1:0] r_count;
    logic              r_err;

    // Count saturates so a very long stall cannot wrap back below the limit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (i_clear) begin
                r_count <= '0;
            end else if (i_count && (r_count != {WDOG_W{1'b1}})) begin
                r_count <= r_count + 1'b1;
            end
            if (r_count == C_LIMIT) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;

endmodule

// File: rtl/pipemem_arbiter.sv
// Arbitrates the single main-memory port between the icache and dcache, one grant per
// memory transaction, with a data-run starvation guard and a grant watchdog.
module pipemem_arbiter
    import pipemem_pkg::*;
#(
    parameter int unsigned MAX_D_RUN = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] i_a,
    input  logic              i_strobe,
    output logic [DATA_W-1:0] i_dout,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] d_a,
    input  logic              d_strobe,
    input  logic              d_rw,
    input  logic [DATA_W-1:0] d_din,
    output logic [DATA_W-1:0] d_dout,
    output logic              d_ready,
    output logic [ADDR_W-1:0] m_a,
    output logic              m_strobe,
    output logic              m_rw,
    output logic [DATA_W-1:0] m_din,
    input  logic [DATA_W-1:0] m_dout,
    input  logic              m_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [RUN_W-1:0] C_MAX_RUN = RUN_W'(MAX_D_RUN);

    arb_state_e        r_state;
    arb_state_e        w_state_next;
    logic [RUN_W-1:0]  r_d_run;
    logic [RUN_W-1:0]  w_d_run_next;
    logic              w_grant;
    logic              w_wd_clear;
    logic              w_wd_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_d_run <= '0;
        end else begin
            r_state <= w_state_next;
            r_d_run <= w_d_run_next;
        end
    end

    // Memory-side outputs are decoded from the registered state, so an asynchronous
    // reset drops m_strobe in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_d_run_next = r_d_run;
        m_strobe     = 1'b0;
        m_a          = '0;
        m_rw         = 1'b0;
        m_din        = '0;
        i_ready      = 1'b0;
        d_ready      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_strobe) begin
                    w_d_run_next = '0;
                end
                if (d_strobe && !(i_strobe && (r_d_run == C_MAX_RUN))) begin
                    w_state_next = GNT_D;
                end else if (i_strobe) begin
                    w_state_next = GNT_I;
                end
            end
            GNT_I: begin
                m_strobe = 1'b1;
                m_a      = i_a;
                i_ready  = m_ready;
                if (m_ready) begin
                    w_state_next = IDLE;
                    w_d_run_next = '0;
                end
            end
            GNT_D: begin
                m_strobe = 1'b1;
                m_a      = d_a;
                m_rw     = d_rw;
                m_din    = d_din;
                d_ready  = m_ready;
                if (m_ready) begin
                    w_state_next = IDLE;
                    if (i_strobe) begin
                        w_d_run_next = run_inc(r_d_run, C_MAX_RUN);
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign i_dout     = m_dout;
    assign d_dout     = m_dout;
    assign w_grant    = (r_state != IDLE);
    assign busy       = w_grant;
    assign w_wd_clear = !w_grant || m_ready;
    assign w_wd_count = w_grant && !m_ready;

    pipemem_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clock  (clock),
        .reset  (reset),
        .i_clear(w_wd_clear),
        .i_count(w_wd_count),
        .o_err  (err)
    );

endmodule

// File: tb/tb_pipemem_arbiter.sv
// Bench for pipemem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipemem_arbiter;

    localparam int MAX_RUN = 4;
    localparam int TMO     = 255;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] i_a = '0, d_a = '0, d_din = '0, m_dout = '0;
    logic        i_strobe = 1'b0, d_strobe = 1'b0, d_rw = 1'b0, m_ready = 1'b0;
    logic [31:0] i_dout, d_dout, m_a, m_din;
    logic        i_ready, d_ready, m_strobe, m_rw, busy, err;

    int n_cmp = 0;
    int n_fail = 0;

    pipemem_arbiter #(.MAX_D_RUN(MAX_RUN), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .i_a(i_a), .i_strobe(i_strobe), .i_dout(i_dout), .i_ready(i_ready),
        .d_a(d_a), .d_strobe(d_strobe), .d_rw(d_rw), .d_din(d_din),
        .d_dout(d_dout), .d_ready(d_ready),
        .m_a(m_a), .m_strobe(m_strobe), .m_rw(m_rw), .m_din(m_din),
        .m_dout(m_dout), .m_ready(m_ready), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int  mem_lat  = 2;
    bit  mem_hold = 1'b0;
    bit  spur     = 1'b0;
    int  rcnt     = 0;
    int  rsp_n    = 0;

    always begin
        @(posedge clock);
        #2;
        if (reset) begin
            rcnt    = 0;
            m_ready = 1'b0;
        end else if (spur) begin
            m_ready = 1'b1;
        end else if (m_strobe && !mem_hold && !m_ready) begin
            rcnt++;
            if (rcnt >= mem_lat) begin
                rcnt    = 0;
                rsp_n++;
                m_dout  = 32'h1000_0000 + 32'(rsp_n);
                m_ready = 1'b1;
            end
        end else begin
            m_ready = 1'b0;
            if (!m_strobe) rcnt = 0;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    typedef struct {
        byte         who;
        logic [31:0] a;
        logic        rw;
        logic [31:0] din;
        logic [31:0] dout;
    } txn_t;
    txn_t log_q[$];

    int owner  = 0;   // 0 = nobody, 1 = icache, 2 = dcache holds the memory port
    int drun   = 0;   // D completions in a row while I was waiting
    int waited = 0;   // grant cycles spent without completion
    bit err_m  = 1'b0;

    always @(negedge clock) begin
        logic [31:0] e_a, e_din;
        logic        e_rw;
        txn_t        t;
        if (reset) begin
            owner = 0; drun = 0; waited = 0; err_m = 1'b0;
        end
        e_a   = (owner == 1) ? i_a : (owner == 2) ? d_a : 32'd0;
        e_rw  = (owner == 2) ? d_rw : 1'b0;
        e_din = (owner == 2) ? d_din : 32'd0;
        chk("m_strobe", 32'(m_strobe), 32'(owner != 0));
        chk("busy",     32'(busy),     32'(owner != 0));
        chk("m_a",      m_a,           e_a);
        chk("m_rw",     32'(m_rw),     32'(e_rw));
        chk("m_din",    m_din,         e_din);
        chk("i_ready",  32'(i_ready),  32'(owner == 1 && m_ready));
        chk("d_ready",  32'(d_ready),  32'(owner == 2 && m_ready));
        chk("i_dout",   i_dout,        m_dout);
        chk("d_dout",   d_dout,        m_dout);
        chk("err",      32'(err),      32'(err_m));
        if (i_ready || d_ready) begin
            t.who  = i_ready ? 8'h49 : 8'h44;
            t.a    = m_a;
            t.rw   = m_rw;
            t.din  = m_din;
            t.dout = i_ready ? i_dout : d_dout;
            log_q.push_back(t);
            $display("txn %0d: %s a=%h rw=%0b din=%h dout=%h", log_q.size(),
                     i_ready ? "I" : "D", t.a, t.rw, t.din, t.dout);
        end
        if (!reset) begin
            if (owner != 0 && waited == TMO) err_m = 1'b1;
            if (owner == 0) begin
                waited = 0;
                if (!i_strobe) drun = 0;
                if (d_strobe && !(i_strobe && drun == MAX_RUN)) owner = 2;
                else if (i_strobe) owner = 1;
            end else if (m_ready) begin
                if (owner == 1) drun = 0;
                else if (i_strobe && drun < MAX_RUN) drun++;
                owner  = 0;
                waited = 0;
            end else begin
                waited++;
            end
        end
    end

    // ---------------- cache-side drivers ----------------
    task automatic i_req(input logic [31:0] a, input int bound);
        bit done = 1'b0;
        i_a = a; i_strobe = 1'b1;
        for (int n = 0; n < bound && !done; n++) begin
            @(negedge clock);
            if (i_ready) done = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL i_req_wait: no i_ready within %0d cycles", bound);
            i_strobe = 1'b0;
        end else begin
            @(posedge clock); #1 i_strobe = 1'b0;
        end
    endtask

    task automatic d_req(input logic [31:0] a, input logic rw, input logic [31:0] din, input int bound);
        bit done = 1'b0;
        d_a = a; d_rw = rw; d_din = din; d_strobe = 1'b1;
        for (int n = 0; n < bound && !done; n++) begin
            @(negedge clock);
            if (d_ready) done = 1'b1;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL d_req_wait: no d_ready within %0d cycles", bound);
            d_strobe = 1'b0;
        end else begin
            @(posedge clock); #1 d_strobe = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int b;
        int pulses;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // Reset in the middle of a data grant.
        mem_hold = 1'b1;
        d_a = 32'h0000_0200; d_rw = 1'b1; d_din = 32'h1234_5678; d_strobe = 1'b1;
        repeat (3) @(negedge clock);
        chk("t1_busy_before_reset", 32'(busy), 32'd1);
        @(posedge clock); #3 reset = 1'b1;
        #1;
        chk("t1_m_strobe_async", 32'(m_strobe), 32'd0);
        chk("t1_busy_async",     32'(busy),     32'd0);
        chk("t1_err_async",      32'(err),      32'd0);
        d_strobe = 1'b0; mem_hold = 1'b0;
        @(posedge clock); #1 reset = 1'b0;

        // Lone instruction miss, memory ready on the third grant cycle.
        mem_lat = 3;
        b = log_q.size();
        i_req(32'h0000_0040, 50);
        chk("t2_count", 32'(log_q.size() - b), 32'd1);
        if (log_q.size() > b) begin
            chk("t2_who",  32'(log_q[b].who), 32'h49);
            chk("t2_a",    log_q[b].a,        32'h0000_0040);
            chk("t2_rw",   32'(log_q[b].rw),  32'd0);
            chk("t2_dout", log_q[b].dout,     32'h1000_0001);
        end

        // Simultaneous requests: data write wins, then instruction after one idle cycle.
        mem_lat = 2;
        @(posedge clock); #1;
        b = log_q.size();
        fork
            i_req(32'h0000_0080, 60);
            d_req(32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 60);
        join
        chk("t3_count", 32'(log_q.size() - b), 32'd2);
        if (log_q.size() >= b + 2) begin
            chk("t3_first_who", 32'(log_q[b].who),  32'h44);
            chk("t3_first_a",   log_q[b].a,         32'h0000_0100);
            chk("t3_first_rw",  32'(log_q[b].rw),   32'd1);
            chk("t3_first_din", log_q[b].din,       32'hDEAD_BEEF);
            chk("t3_second_who", 32'(log_q[b+1].who), 32'h49);
            chk("t3_second_a",  log_q[b+1].a,       32'h0000_0080);
        end

        // Starvation guard: D held continuously with I pending.
        @(posedge clock); #1;
        b = log_q.size();
        i_a = 32'h0000_0300; i_strobe = 1'b1;
        d_a = 32'h0000_0400; d_rw = 1'b0; d_din = 32'd0; d_strobe = 1'b1;
        pulses = 0;
        for (int n = 0; n < 200 && pulses < 6; n++) begin
            @(negedge clock);
            if (i_ready || d_ready) pulses++;
        end
        if (pulses < 6) begin
            n_cmp++; n_fail++;
            $display("FAIL t4_wait: only %0d completions", pulses);
        end
        @(posedge clock); #1 i_strobe = 1'b0; d_strobe = 1'b0;
        if (log_q.size() >= b + 6) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("t4_grant%0d_who", k + 1), 32'(log_q[b+k].who),
                    (k == 4) ? 32'h49 : 32'h44);
            end
        end else begin
            chk("t4_count", 32'(log_q.size() - b), 32'd6);
        end

        // Spurious m_ready while idle.
        repeat (2) @(posedge clock);
        #1 spur = 1'b1;
        b = log_q.size();
        @(negedge clock);
        chk("t6_busy_idle", 32'(busy), 32'd0);
        @(posedge clock); #1 spur = 1'b0;
        repeat (2) @(negedge clock);
        chk("t6_no_txn", 32'(log_q.size() - b), 32'd0);
        chk("t6_still_idle", 32'(busy), 32'd0);

        // Timeout: memory withholds ready well past TIMEOUT cycles.
        @(posedge clock); #1;
        mem_hold = 1'b1;
        b = log_q.size();
        fork
            i_req(32'h0000_0500, 400);
            begin
                repeat (250) @(negedge clock);
                chk("t5_err_not_yet", 32'(err), 32'd0);
                repeat (20) @(negedge clock);
                chk("t5_err_set", 32'(err), 32'd1);
                @(posedge clock); #1 mem_hold = 1'b0;
            end
        join
        chk("t5_count", 32'(log_q.size() - b), 32'd1);
        if (log_q.size() > b) chk("t5_who", 32'(log_q[b].who), 32'h49);
        repeat (3) @(negedge clock);
        chk("t5_err_sticky", 32'(err), 32'd1);

        // Reset clears the sticky error.
        @(posedge clock); #3 reset = 1'b1;
        #1 chk("t7_err_cleared", 32'(err), 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("t7_err_stays_clear", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
